mem_port_arbiter: RTL

Sequences the single shared instruction/data memory port between the IF stage (instruction fetch) and the MEM stage (load/store).
Drives freeze_if / flush_if into the IF stage register and PC, and freeze_pipe into the later pipeline registers.
Handles multi-cycle memory latency via a req/ready handshake.
Discards in-flight fetches when a branch is taken.

---
 rtl/arb_pkg.sv | 15 +
 rtl/sat_counter.sv | 28 ++
 rtl/mem_port_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DATA    = 2'd2,
        DISCARD = 2'd3
    } arb_state_t;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;
    localparam int PERF_W     = 32;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
// Only compiled into the design when ARB_PERF_CNT_EN is defined.
`ifdef ARB_PERF_CNT_EN
module sat_counter
    import arb_pkg::*;
#(
    parameter int W = PERF_W
) (
    input  logic         i_clk,
    input  logic         i_clr_n,
    input  logic         i_en,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (!i_clr_n) begin
            r_cnt <= '0;
        end else if (i_en && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_cnt = r_cnt;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single shared memory port between instruction fetch and load/store.
// Optional stall counters are enabled with the macro ARB_PERF_CNT_EN.
module mem_port_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_instr,
    output logic              if_valid,
    input  logic              branch_taken,
    output logic              flush_if,
    output logic              freeze_if,
    input  logic              mem_rd_en,
    input  logic              mem_wr_en,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_done,
    output logic              freeze_pipe,
    output logic              p_req,
    output logic              p_we,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    input  logic [DATA_W-1:0] p_rdata,
    input  logic              p_ready,
    output logic [PERF_W-1:0] fetch_stall_cnt,
    output logic [PERF_W-1:0] data_stall_cnt,
    output logic [1:0]        o_dbg_state
);

    // Port handshake: p_req/p_addr/p_we/p_wdata are held stable from the cycle
    // after a grant until the cycle where p_req & p_ready, which completes it.
    arb_state_t        r_state;
    arb_state_t        w_next_state;
    logic              r_fetch_prio;
    logic              r_p_req;
    logic              r_p_we;
    logic [ADDR_W-1:0] r_p_addr;
    logic [DATA_W-1:0] r_p_wdata;
    logic [DATA_W-1:0] r_if_instr;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_mem_rdata;
    logic              r_mem_done;

    logic w_data_req;
    logic w_complete;
    logic w_grant_data;
    logic w_grant_fetch;
    logic w_fetch_done;
    logic w_data_done;

    assign w_data_req = mem_rd_en | mem_wr_en;
    assign w_complete = r_p_req & p_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // During the mem_done cycle the enables still belong to the finished access.
    always_comb begin
        w_next_state  = r_state;
        w_grant_data  = 1'b0;
        w_grant_fetch = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_data_req && !r_mem_done && !(r_fetch_prio && if_req)) begin
                    w_grant_data = 1'b1;
                    w_next_state = DATA;
                end else if (if_req) begin
                    w_grant_fetch = 1'b1;
                    w_next_state  = FETCH;
                end
            end
            FETCH: begin
                if (w_complete) begin
                    w_next_state = IDLE;
                end else if (branch_taken) begin
                    w_next_state = DISCARD;
                end
            end
            DATA, DISCARD: begin
                if (w_complete) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // A fetch completing in the same cycle as a taken branch is dropped.
    assign w_fetch_done = (r_state == FETCH) & w_complete & ~branch_taken;
    assign w_data_done  = (r_state == DATA) & w_complete;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_fetch_prio <= 1'b0;
            r_p_req      <= 1'b0;
            r_p_we       <= 1'b0;
            r_p_addr     <= '0;
            r_p_wdata    <= '0;
            r_if_instr   <= '0;
            r_if_valid   <= 1'b0;
            r_mem_rdata  <= '0;
            r_mem_done   <= 1'b0;
        end else begin
            r_if_valid <= w_fetch_done;
            r_mem_done <= w_data_done;
            if (w_fetch_done) begin
                r_if_instr <= p_rdata;
            end
            if (w_data_done && !r_p_we) begin
                r_mem_rdata <= p_rdata;
            end
            if (w_grant_data) begin
                r_p_req   <= 1'b1;
                r_p_addr  <= mem_addr;
                r_p_wdata <= mem_wdata;
                r_p_we    <= mem_wr_en;
            end else if (w_grant_fetch) begin
                r_p_req  <= 1'b1;
                r_p_addr <= if_addr;
                r_p_we   <= 1'b0;
            end else if (w_complete) begin
                r_p_req <= 1'b0;
            end
            if (w_data_done) begin
                r_fetch_prio <= 1'b1;
            end else if (w_grant_fetch) begin
                r_fetch_prio <= 1'b0;
            end
        end
    end

    assign if_instr    = r_if_instr;
    assign if_valid    = r_if_valid;
    assign mem_rdata   = r_mem_rdata;
    assign mem_done    = r_mem_done;
    assign p_req       = r_p_req;
    assign p_we        = r_p_we;
    assign p_addr      = r_p_addr;
    assign p_wdata     = r_p_wdata;
    assign o_dbg_state = r_state;

    assign flush_if    = rst & branch_taken;
    assign freeze_pipe = rst & w_data_req & ~r_mem_done;
    assign freeze_if   = rst & (~r_if_valid | freeze_pipe);

`ifdef ARB_PERF_CNT_EN
    logic w_fetch_stall_en;
    logic w_data_stall_en;

    assign w_fetch_stall_en = freeze_if & ~freeze_pipe;
    assign w_data_stall_en  = freeze_pipe;

    sat_counter #(.W(PERF_W)) u_fetch_stall_cnt (
        .i_clk   (clk),
        .i_clr_n (rst),
        .i_en    (w_fetch_stall_en),
        .o_cnt   (fetch_stall_cnt)
    );

    sat_counter #(.W(PERF_W)) u_data_stall_cnt (
        .i_clk   (clk),
        .i_clr_n (rst),
        .i_en    (w_data_stall_en),
        .o_cnt   (data_stall_cnt)
    );
`else
    assign fetch_stall_cnt = '0;
    assign data_stall_cnt  = '0;
`endif

endmodule
